// File: rtl/dmtd_pll_sequencer.sv
// dmtd_pll_sequencer
//   Brings up the DMTD helper PLL: it holds the PLL in reset, waits for lock,
//   requires the lock to stay up for a while, and then releases the logic
//   clocked by the PLL output. Lock loss in READY restarts the sequence and is
//   counted. Repeated lock timeouts end in FAULT until the block is disabled.
//
// Ports
//   clk_sys_i        system clock (unrelated to the PLL output)
//   rst_n_i          asynchronous active-low reset (deassertion synchronized here)
//   en_i             sequencer enable, 0 forces IDLE
//   locked_i         raw PLL lock flag, asynchronous to clk_sys_i
//   cnt_clr_i        synchronous clear of lock_loss_cnt_o
//   pll_rst_o        active-high PLL reset
//   pll_ready_o      PLL locked and stable
//   dmtd_rst_n_o     active-low reset for the PLL-clocked logic (= pll_ready_o)
//   fault_o          lock retries exhausted
//   lock_loss_cnt_o  saturating count of lock losses seen in READY
module dmtd_pll_sequencer #(
    parameter int g_rst_cycles    = 20,
    parameter int g_lock_timeout  = 100000,
    parameter int g_stable_cycles = 1024,
    parameter int g_max_retries   = 3
) (
    input  logic        clk_sys_i,
    input  logic        rst_n_i,
    input  logic        en_i,
    input  logic        locked_i,
    input  logic        cnt_clr_i,
    output logic        pll_rst_o,
    output logic        pll_ready_o,
    output logic        dmtd_rst_n_o,
    output logic        fault_o,
    output logic [15:0] lock_loss_cnt_o
);

    localparam int RST_W  = (g_rst_cycles > 1)    ? $clog2(g_rst_cycles)      : 1;
    localparam int TO_W   = (g_lock_timeout > 1)  ? $clog2(g_lock_timeout)    : 1;
    localparam int STAB_W = (g_stable_cycles > 1) ? $clog2(g_stable_cycles)   : 1;
    localparam int RTY_W  = (g_max_retries > 0)   ? $clog2(g_max_retries + 1) : 1;

    localparam logic [RST_W-1:0]  RST_LAST  = RST_W'(g_rst_cycles - 1);
    localparam logic [TO_W-1:0]   TO_LAST   = TO_W'(g_lock_timeout - 1);
    localparam logic [STAB_W-1:0] STAB_LAST = STAB_W'(g_stable_cycles - 1);
    localparam logic [RTY_W-1:0]  RTY_MAX   = RTY_W'(g_max_retries);
    localparam logic [15:0]       LOSS_MAX  = 16'hFFFF;

    typedef enum logic [2:0] {
        S_IDLE      = 3'd0,
        S_RESET     = 3'd1,
        S_WAIT_LOCK = 3'd2,
        S_STABLE    = 3'd3,
        S_READY     = 3'd4,
        S_FAULT     = 3'd5
    } state_t;

    state_t state, next_state;

    logic [1:0]        rst_pipe;
    logic              sys_rst_n;
    logic [1:0]        lock_pipe;
    logic              lock_s;
    logic [RST_W-1:0]  rst_cnt;
    logic [TO_W-1:0]   to_cnt;
    logic [STAB_W-1:0] stab_cnt;
    logic [RTY_W-1:0]  retry_cnt;
    logic [RTY_W-1:0]  retry_next;
    logic              retry_clr;
    logic              retry_bump;
    logic              loss_event;
    logic              pll_rst_q;
    logic              ready_q;
    logic              fault_q;
    logic [15:0]       loss_cnt;

    // Reset asserts straight through, deasserts two clk_sys_i edges later so
    // no flop below sees a release close to the clock edge.
    always_ff @(posedge clk_sys_i or negedge rst_n_i) begin
        if (!rst_n_i) rst_pipe <= '0;
        else          rst_pipe <= {rst_pipe[0], 1'b1};
    end
    assign sys_rst_n = rst_pipe[1];

    // Two-flop synchronizer for the PLL lock flag.
    always_ff @(posedge clk_sys_i or negedge sys_rst_n) begin
        if (!sys_rst_n) lock_pipe <= '0;
        else            lock_pipe <= {lock_pipe[0], locked_i};
    end
    assign lock_s = lock_pipe[1];

    assign retry_next = retry_cnt + 1'b1;

    always_ff @(posedge clk_sys_i or negedge sys_rst_n) begin
        if (!sys_rst_n) state <= S_IDLE;
        else            state <= next_state;
    end

    always_comb begin
        next_state = state;
        retry_clr  = 1'b0;
        retry_bump = 1'b0;
        loss_event = 1'b0;
        if (!en_i) begin
            next_state = S_IDLE;
        end else begin
            case (state)
                S_IDLE: begin
                    next_state = S_RESET;
                    retry_clr  = 1'b1;
                end
                S_RESET: begin
                    if (rst_cnt == RST_LAST) next_state = S_WAIT_LOCK;
                end
                S_WAIT_LOCK: begin
                    // Lock seen on the last timeout cycle still counts as lock.
                    if (lock_s) begin
                        next_state = S_STABLE;
                    end else if (to_cnt == TO_LAST) begin
                        retry_bump = 1'b1;
                        if (g_max_retries != 0 && retry_next == RTY_MAX)
                            next_state = S_FAULT;
                        else
                            next_state = S_RESET;
                    end
                end
                S_STABLE: begin
                    // A dropout only restarts the wait; it is not a retry.
                    if (!lock_s)                    next_state = S_WAIT_LOCK;
                    else if (stab_cnt == STAB_LAST) next_state = S_READY;
                end
                S_READY: begin
                    if (!lock_s) begin
                        next_state = S_RESET;
                        retry_clr  = 1'b1;
                        loss_event = 1'b1;
                    end
                end
                S_FAULT: next_state = S_FAULT;
                default: next_state = S_IDLE;
            endcase
        end
    end

    // Per-state cycle counters: cleared whenever the state is entered or left,
    // so each one only runs while its state persists and never wraps there.
    always_ff @(posedge clk_sys_i or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            rst_cnt  <= '0;
            to_cnt   <= '0;
            stab_cnt <= '0;
        end else begin
            rst_cnt  <= (state == S_RESET && next_state == S_RESET) ?
                        rst_cnt + 1'b1 : '0;
            to_cnt   <= (state == S_WAIT_LOCK && next_state == S_WAIT_LOCK) ?
                        to_cnt + 1'b1 : '0;
            stab_cnt <= (state == S_STABLE && next_state == S_STABLE) ?
                        stab_cnt + 1'b1 : '0;
        end
    end

    // With unlimited retries the count is never consulted, so it stays at 0.
    always_ff @(posedge clk_sys_i or negedge sys_rst_n) begin
        if (!sys_rst_n)                            retry_cnt <= '0;
        else if (retry_clr)                        retry_cnt <= '0;
        else if (retry_bump && g_max_retries != 0) retry_cnt <= retry_next;
    end

    always_ff @(posedge clk_sys_i or negedge sys_rst_n) begin
        if (!sys_rst_n)                                  loss_cnt <= '0;
        else if (cnt_clr_i)                              loss_cnt <= '0;
        else if (loss_event && loss_cnt != LOSS_MAX)     loss_cnt <= loss_cnt + 16'd1;
    end

    // Outputs are registered from the next state so they change on the same
    // edge as the state: leaving READY drops ready and raises pll_rst together.
    always_ff @(posedge clk_sys_i or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            pll_rst_q <= 1'b1;
            ready_q   <= 1'b0;
            fault_q   <= 1'b0;
        end else begin
            pll_rst_q <= (next_state == S_IDLE) || (next_state == S_RESET) ||
                         (next_state == S_FAULT);
            ready_q   <= (next_state == S_READY);
            fault_q   <= (next_state == S_FAULT);
        end
    end

    assign pll_rst_o       = pll_rst_q;
    assign pll_ready_o     = ready_q;
    assign dmtd_rst_n_o    = ready_q;
    assign fault_o         = fault_q;
    assign lock_loss_cnt_o = loss_cnt;

endmodule

// File: tb/tb_dmtd_pll_sequencer.sv
// Bench for dmtd_pll_sequencer: a cycle-level behavioural model of the
// sequencing rules is compared with the DUT on every falling edge, and
// directed scenarios pin measured durations to hand-computed values.
module tb_dmtd_pll_sequencer;

    localparam int RC = 4;
    localparam int TO = 50;
    localparam int SC = 8;
    localparam int MR = 2;

    localparam int M_IDLE   = 0;
    localparam int M_RESET  = 1;
    localparam int M_WAIT   = 2;
    localparam int M_STABLE = 3;
    localparam int M_READY  = 4;
    localparam int M_FAULT  = 5;

    logic        clk     = 1'b0;
    logic        rst_n   = 1'b0;
    logic        en      = 1'b0;
    logic        locked  = 1'b0;
    logic        cnt_clr = 1'b0;
    logic        pll_rst;
    logic        pll_ready;
    logic        dmtd_rst_n;
    logic        fault;
    logic [15:0] loss;

    int n_checks = 0;
    int n_errors = 0;
    bit cmp_en   = 1'b0;
    int rst_hi_cycles = 0;

    always #5 clk = ~clk;

    dmtd_pll_sequencer #(
        .g_rst_cycles   (RC),
        .g_lock_timeout (TO),
        .g_stable_cycles(SC),
        .g_max_retries  (MR)
    ) dut (
        .clk_sys_i      (clk),
        .rst_n_i        (rst_n),
        .en_i           (en),
        .locked_i       (locked),
        .cnt_clr_i      (cnt_clr),
        .pll_rst_o      (pll_rst),
        .pll_ready_o    (pll_ready),
        .dmtd_rst_n_o   (dmtd_rst_n),
        .fault_o        (fault),
        .lock_loss_cnt_o(loss)
    );

    // ---------------- behavioural model ----------------
    // rel: reset-release delay line, lk: lock flag seen two edges late.
    int      m_mode, m_cnt, m_retries, m_loss;
    bit [1:0] m_rel, m_lk;

    always @(posedge clk or negedge rst_n) begin : model
        int nm;
        bit lk_now, lost;
        if (!rst_n) begin
            m_rel = '0; m_lk = '0; m_mode = M_IDLE; m_cnt = 0;
            m_retries = 0; m_loss = 0;
        end else begin
            if (m_rel[1]) begin
                lk_now = m_lk[1];
                m_lk   = {m_lk[0], locked};
                nm     = m_mode;
                lost   = 1'b0;
                if (!en) nm = M_IDLE;
                else begin
                    case (m_mode)
                        M_IDLE:   begin nm = M_RESET; m_retries = 0; end
                        M_RESET:  if (m_cnt + 1 >= RC) nm = M_WAIT;
                        M_WAIT:   if (lk_now) nm = M_STABLE;
                                  else if (m_cnt + 1 >= TO) begin
                                      m_retries++;
                                      nm = (MR != 0 && m_retries == MR) ? M_FAULT : M_RESET;
                                  end
                        M_STABLE: if (!lk_now) nm = M_WAIT;
                                  else if (m_cnt + 1 >= SC) nm = M_READY;
                        M_READY:  if (!lk_now) begin nm = M_RESET; m_retries = 0; lost = 1'b1; end
                        default:  nm = m_mode;
                    endcase
                end
                if (cnt_clr) m_loss = 0;
                else if (lost && m_loss < 65535) m_loss++;
                m_cnt  = (nm == m_mode) ? m_cnt + 1 : 0;
                m_mode = nm;
            end else begin
                m_lk = '0;
            end
            m_rel = {m_rel[0], 1'b1};
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s at %0t: got %0d, expected %0d", name, $time, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (pll_rst === 1'b1) rst_hi_cycles++;
        if (cmp_en) begin
            check("pll_rst_o",    32'(pll_rst),    32'(m_mode == M_IDLE || m_mode == M_RESET || m_mode == M_FAULT));
            check("pll_ready_o",  32'(pll_ready),  32'(m_mode == M_READY));
            check("dmtd_rst_n_o", 32'(dmtd_rst_n), 32'(m_mode == M_READY));
            check("fault_o",      32'(fault),      32'(m_mode == M_FAULT));
            check("lock_loss",    32'(loss),       32'(m_loss));
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    function automatic logic out_sel(input int sel);
        case (sel)
            0:       return pll_rst;
            1:       return pll_ready;
            default: return fault;
        endcase
    endfunction

    // Counts rising edges until the selected output reaches val (bounded).
    task automatic wait_for(input int sel, input logic val, input int max, output int n);
        n = 0;
        while (out_sel(sel) !== val && n < max) begin
            @(posedge clk);
            #1;
            n++;
        end
        if (out_sel(sel) !== val) begin
            n_checks++;
            n_errors++;
            $display("FAIL wait_out%0d: still %b after %0d cycles, wanted %b", sel, out_sel(sel), n, val);
        end
    endtask

    initial begin
        int n, snap;

        // Reset state.
        @(posedge clk);
        #1;
        cmp_en = 1'b1;
        check("rst_pll_rst",   32'(pll_rst),    32'd1);
        check("rst_ready",     32'(pll_ready),  32'd0);
        check("rst_dmtd",      32'(dmtd_rst_n), 32'd0);
        check("rst_fault",     32'(fault),      32'd0);
        check("rst_loss",      32'(loss),       32'd0);
        tick(2);
        rst_n = 1'b1;
        tick(4);

        // Nominal bring-up: IDLE edge + 4 RESET cycles, lock 10 cycles later.
        en = 1'b1;
        wait_for(0, 1'b0, 20, n);
        check("nom_rst_edges", 32'(n), 32'd5);
        tick(10);
        locked = 1'b1;
        wait_for(1, 1'b1, 100, n);
        check("nom_ready_lat", 32'(n), 32'd11);

        // Lock loss in READY.
        locked = 1'b0;
        wait_for(1, 1'b0, 10, n);
        check("loss_lat",      32'(n), 32'd3);
        check("loss_pll_rst",  32'(pll_rst), 32'd1);
        check("loss_cnt1",     32'(loss), 32'd1);
        locked = 1'b1;
        wait_for(1, 1'b1, 100, n);
        check("relock_lat",    32'(n), 32'd13);

        // Clear coincident with an increment.
        locked = 1'b0;
        tick(2);
        cnt_clr = 1'b1;
        tick(1);
        cnt_clr = 1'b0;
        check("clr_wins",      32'(loss), 32'd0);
        check("clr_ready",     32'(pll_ready), 32'd0);

        // Glitch in STABLE: 5 locked, 3 unlocked, relock.
        wait_for(0, 1'b0, 20, n);
        check("glitch_rst_len", 32'(n), 32'd4);
        tick(3);
        snap = rst_hi_cycles;
        locked = 1'b1;
        tick(5);
        locked = 1'b0;
        tick(3);
        locked = 1'b1;
        wait_for(1, 1'b1, 100, n);
        check("glitch_ready_lat", 32'(n), 32'd11);
        check("glitch_no_reset",  32'(rst_hi_cycles - snap), 32'd0);

        // Timeouts ending in FAULT.
        locked = 1'b0;
        wait_for(0, 1'b1, 10, n);
        check("to_loss_lat",   32'(n), 32'd3);
        check("to_loss_cnt",   32'(loss), 32'd1);
        wait_for(0, 1'b0, 10, n);
        check("to_reset1",     32'(n), 32'd4);
        wait_for(0, 1'b1, 60, n);
        check("to_wait1",      32'(n), 32'd50);
        wait_for(0, 1'b0, 10, n);
        check("to_reset2",     32'(n), 32'd4);
        wait_for(2, 1'b1, 60, n);
        check("to_wait2",      32'(n), 32'd50);
        check("fault_pll_rst", 32'(pll_rst), 32'd1);
        tick(5);
        check("fault_held",    32'(fault), 32'd1);
        en = 1'b0;
        tick(1);
        check("fault_clear",   32'(fault), 32'd0);
        check("idle_pll_rst",  32'(pll_rst), 32'd1);

        // Async reset during WAIT_LOCK.
        en = 1'b1;
        wait_for(0, 1'b0, 20, n);
        check("ar_rst_edges",  32'(n), 32'd5);
        tick(5);
        @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check("ar_pll_rst",    32'(pll_rst),    32'd1);
        check("ar_ready",      32'(pll_ready),  32'd0);
        check("ar_dmtd",       32'(dmtd_rst_n), 32'd0);
        check("ar_fault",      32'(fault),      32'd0);
        check("ar_loss",       32'(loss),       32'd0);
        en = 1'b0;
        tick(3);
        rst_n = 1'b1;
        tick(4);

        // Bring-up with lock already present.
        en = 1'b1;
        locked = 1'b1;
        wait_for(1, 1'b1, 100, n);
        check("prelock_lat",   32'(n), 32'd14);
        tick(5);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

// File: doc/dmtd_pll_sequencer.md
DMTD_PLL_SEQUENCER -- requirements
Module: dmtd_pll_sequencer

Interface
REQ-001 The block SHALL have one clock; reset is asynchronous and active-low.
REQ-002 Parameter g_rst_cycles, default 20: number of cycles the PLL reset is held per attempt (>=1).
REQ-003 Parameter g_lock_timeout, default 100000: cycles allowed in WAIT_LOCK before a retry (>=1).
REQ-004 Parameter g_stable_cycles, default 1024: consecutive synchronized-lock cycles required before READY (>=1).
REQ-005 Parameter g_max_retries, default 3: timeouts tolerated before FAULT; 0 means unlimited.
REQ-006 clk_sys_i  in  1  free-running system clock, unrelated to the PLL output.
REQ-007 rst_n_i  in  1  asynchronous active-low reset.
REQ-008 en_i  in  1  sequencer enable; 0 forces IDLE.
REQ-009 locked_i  in  1  raw PLL lock flag, asynchronous to clk_sys_i.
REQ-010 cnt_clr_i  in  1  synchronous clear of lock_loss_cnt_o.
REQ-011 pll_rst_o  out  1  active-high reset to the PLL.
REQ-012 pll_ready_o  out  1  PLL locked and stable.
REQ-013 dmtd_rst_n_o  out  1  active-low reset for logic clocked by the PLL output, equal to pll_ready_o.
REQ-014 fault_o  out  1  retries exhausted.
REQ-015 lock_loss_cnt_o  out  16  saturating count of lock losses seen in READY.

Function
REQ-016 locked_i SHALL pass through a 2-flop synchronizer, producing lock_s, before any use.
REQ-017 All outputs SHALL be registered and decoded from state, with no combinational path from inputs.
REQ-018 States SHALL be: IDLE, RESET, WAIT_LOCK, STABLE, READY and FAULT.
REQ-019 pll_rst_o SHALL be 1 in IDLE, RESET and FAULT, and 0 in WAIT_LOCK, STABLE and READY.
REQ-020 IDLE: en_i=1 SHALL go to RESET, clearing the retry counter.
REQ-021 RESET SHALL last exactly g_rst_cycles cycles and then go to WAIT_LOCK with the timeout counter cleared.
REQ-022 WAIT_LOCK: lock_s=1 SHALL go to STABLE with the stable counter cleared.
REQ-023 WAIT_LOCK: after g_lock_timeout cycles without lock, the retry counter SHALL increment, with two outcomes:
- If the incremented value equals g_max_retries (when g_max_retries is nonzero), go to FAULT.
- Otherwise, go to RESET.
REQ-024 STABLE: after g_stable_cycles consecutive cycles with lock_s=1, SHALL go to READY.
REQ-025 STABLE: lock_s=0 SHALL go to WAIT_LOCK with the timeout counter restarted and no retry increment.
REQ-026 READY: pll_ready_o=1 and dmtd_rst_n_o=1.
REQ-027 READY: lock_s=0 SHALL do all of the following:
- Increment lock_loss_cnt_o, saturating at 0xFFFF.
- Clear the retry counter.
- Go to RESET.
REQ-028 FAULT: fault_o=1, held until en_i=0.
REQ-029 en_i=0 in any state SHALL give IDLE on the next cycle and clear fault_o; en_i has priority over every other transition.
REQ-030 cnt_clr_i=1 SHALL zero lock_loss_cnt_o next cycle; it wins over a simultaneous increment.
REQ-031 pll_ready_o SHALL deassert on the cycle READY is left, in the same cycle pll_rst_o asserts.
REQ-032 Counters SHALL be sized by clog2 of their parameter and SHALL NOT wrap within a state.

Reset
REQ-033 While rst_n_i=0, the following SHALL hold:
- state=IDLE.
- pll_rst_o=1.
- pll_ready_o=0, dmtd_rst_n_o=0, fault_o=0.
- lock_loss_cnt_o=0.
- Synchronizer flops and all internal counters 0.
REQ-034 Asserting reset mid-sequence SHALL reach these values immediately (asynchronously); deassertion is synchronized to clk_sys_i internally.

Verification
Bench parameters: g_rst_cycles=4, g_lock_timeout=50, g_stable_cycles=8, g_max_retries=2.
REQ-035 Nominal: en_i=1, locked_i rises 10 cycles after pll_rst_o falls -> pll_rst_o high exactly 4 cycles; pll_ready_o rises 2+8 cycles (+1 registered) after locked_i; fault_o=0.
REQ-036 Timeout/fault: locked_i held 0 -> two RESET pulses of 4 cycles, each followed by a 50-cycle wait; then fault_o=1 with pll_rst_o=1; en_i=0 -> IDLE and fault_o=0 next cycle.
REQ-037 Glitch in STABLE: locked_i low for 3 cycles after 5 locked cycles -> no READY and no RESET pulse; READY reached 8 stable cycles after relock.
REQ-038 Lock loss: in READY, locked_i=0 -> lock_loss_cnt_o 0->1; pll_ready_o=0 and pll_rst_o=1 on the same cycle; the sequence returns to READY after relock.
REQ-039 Counter clear: cnt_clr_i=1 coincident with a lock-loss increment -> lock_loss_cnt_o=0.
REQ-040 Async reset: rst_n_i=0 during WAIT_LOCK -> all outputs take their reset values without a clock edge.
